// File: rtl/apb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_pkg : shared APB slave types, ID constant and byte-strobe merge helper
// rev 1.0
// ---------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE  = 2'd0,
    APB_SETUP = 2'd1,
    APB_WAIT  = 2'd2,
    APB_RESP  = 2'd3
  } apb_state_e;

  localparam logic [15:0] APB_ID_MAGIC = 16'hA9B0;
  localparam int          APB_DATA_W   = 32;
  localparam int          APB_STRB_W   = APB_DATA_W / 8;

  function automatic logic [APB_DATA_W-1:0] apb_strb_merge(
    input logic [APB_DATA_W-1:0] old,
    input logic [APB_DATA_W-1:0] wdata,
    input logic [APB_STRB_W-1:0] strb
  );
    logic [APB_DATA_W-1:0] merged;
    merged = old;
    for (int b = 0; b < APB_STRB_W; b++) begin
      if (strb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_regfile_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_regfile_mem : DEPTH x 32 storage, byte-enable write, combinational read
// rev 1.0
// ---------------------------------------------------------------------------
module apb_regfile_mem
  import apb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [APB_STRB_W-1:0] wstrb,
  input  logic [IDX_W-1:0]      raddr,
  output logic [APB_DATA_W-1:0] rdata
);

  logic [APB_DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= apb_strb_merge(mem_q[waddr], wdata, wstrb);
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_slave_regfile : APB3 slave with byte-strobed register file and
//                     programmable wait states; word 0 is a read-only ID.
// rev 1.0
// ---------------------------------------------------------------------------
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int SLAVE_ID    = 0,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int                    IDX_W   = $clog2(DEPTH);
  localparam int                    STRB_W  = DATA_WIDTH / 8;
  localparam logic [3:0]            WS_C    = 4'(WAIT_STATES);
  localparam logic [31:0]           DEPTH_U = 32'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] ID_WORD = {APB_ID_MAGIC, 8'(DEPTH), 8'(SLAVE_ID)};

  apb_state_e              state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       strb_q, strb_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;

  logic                    begin_setup;
  logic                    capture;
  logic                    take_resp;
  logic [ADDR_WIDTH-1:0]   src_addr;
  logic                    src_write;
  logic [ADDR_WIDTH-3:0]   idx_full;
  logic [31:0]             idx_ext;
  logic                    dec_err;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    mem_we;

  assign begin_setup = psel && !penable;

  // With zero wait states the response is decided in the setup cycle itself,
  // so decode must look at the live bus rather than the captured copy.
  always_comb begin
    src_addr  = (state_q == APB_IDLE) ? paddr  : addr_q;
    src_write = (state_q == APB_IDLE) ? pwrite : write_q;
    idx_full  = src_addr[ADDR_WIDTH-1:2];
    idx_ext   = 32'(idx_full);
    dec_err   = (src_addr[1:0] != 2'b00) || (idx_ext >= DEPTH_U) ||
                (src_write && (idx_ext == 32'd0));
    if (dec_err || src_write) begin
      resp_rdata = '0;
    end else if (idx_ext == 32'd0) begin
      resp_rdata = ID_WORD;
    end else begin
      resp_rdata = mem_rdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    take_resp = 1'b0;

    case (state_q)
      APB_IDLE: begin
        if (begin_setup) begin
          capture = 1'b1;
          if (WS_C == 4'd0) begin
            state_d   = APB_RESP;
            take_resp = 1'b1;
          end else begin
            // The first access cycle spent in SETUP already counts as a wait.
            state_d = APB_SETUP;
            cnt_d   = WS_C - 4'd1;
          end
        end
      end
      APB_SETUP: begin
        if (!psel) begin
          state_d = APB_IDLE;
        end else if (!penable) begin
          capture = 1'b1;
        end else if (cnt_q == 4'd0) begin
          state_d   = APB_RESP;
          take_resp = 1'b1;
        end else begin
          state_d = APB_WAIT;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      APB_WAIT: begin
        if (!psel || !penable) begin
          state_d = APB_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d   = APB_RESP;
          take_resp = 1'b1;
        end
      end
      APB_RESP: begin
        // A setup overlapping the response cycle is held one extra cycle,
        // keeping back-to-back completions 1+WAIT_STATES+1 cycles apart.
        if (begin_setup) begin
          capture = 1'b1;
          state_d = APB_SETUP;
          cnt_d   = WS_C;
        end else begin
          state_d = APB_IDLE;
        end
      end
      default: state_d = APB_IDLE;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    if (capture) begin
      addr_d  = paddr;
      write_d = pwrite;
      wdata_d = pwdata;
      strb_d  = pstrb;
    end
    if (take_resp) begin
      pready_d  = 1'b1;
      pslverr_d = dec_err;
      prdata_d  = resp_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= APB_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // The write lands at the end of the response cycle, only if it was legal.
  assign mem_we = (state_q == APB_RESP) && write_q && !pslverr_q;

  apb_regfile_mem #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (addr_q[IDX_W+1:2]),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .raddr (idx_full[IDX_W-1:0]),
    .rdata (mem_rdata)
  );

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_apb_slave_regfile : directed self-checking bench for apb_slave_regfile
// rev 1.0
// ---------------------------------------------------------------------------
module tb_apb_slave_regfile;

  logic        clk;
  logic        rst_n;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  apb_slave_regfile #(
    .SLAVE_ID    (0),
    .ADDR_WIDTH  (8),
    .DATA_WIDTH  (32),
    .DEPTH       (16),
    .WAIT_STATES (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One full transfer; lat is the cycle (relative to setup) where pready rose.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd,
                      output logic er, output int lat);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    tick();
    penable = 1'b1;
    lat = 1;
    while (!pready && lat < 40) begin
      tick();
      lat++;
    end
    if (!pready) lat = -1;
    rd = prdata;
    er = pslverr;
    psel = 1'b0; penable = 1'b0;
    tick();
    check("pready_one_cycle", {31'd0, pready}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          n;
  int          r1;
  logic        seen;

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) tick();
    check("rst_pready",  {31'd0, pready},  32'd0);
    check("rst_pslverr", {31'd0, pslverr}, 32'd0);
    check("rst_prdata",  prdata,           32'd0);
    rst_n = 1'b1;
    tick();

    // penable without a setup phase must be ignored
    psel = 1'b1; penable = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (pready) seen = 1'b1;
    end
    check("no_setup_pready", {31'd0, seen}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    tick();

    xfer(1'b0, 8'h00, 32'h0, 4'h0, rd, er, lat);
    check("id_latency", lat, 32'd3);
    check("id_data",    rd,  32'hA9B0_1000);
    check("id_err",     {31'd0, er}, 32'd0);

    xfer(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check("wr04_latency", lat, 32'd3);
    check("wr04_err",     {31'd0, er}, 32'd0);
    check("wr04_prdata",  rd, 32'd0);
    xfer(1'b0, 8'h04, 32'h0, 4'h0, rd, er, lat);
    check("rd04_latency", lat, 32'd3);
    check("rd04_data",    rd, 32'hDEADBEEF);

    xfer(1'b1, 8'h08, 32'h1122_3344, 4'b0101, rd, er, lat);
    check("wr08_err", {31'd0, er}, 32'd0);
    xfer(1'b0, 8'h08, 32'h0, 4'h0, rd, er, lat);
    check("rd08_strb", rd, 32'h0022_0044);

    // error cases
    xfer(1'b1, 8'h00, 32'h5555_5555, 4'hF, rd, er, lat);
    check("err_wr00",     {31'd0, er}, 32'd1);
    check("err_wr00_lat", lat, 32'd3);
    xfer(1'b0, 8'h00, 32'h0, 4'h0, rd, er, lat);
    check("id_unchanged", rd, 32'hA9B0_1000);

    xfer(1'b1, 8'h40, 32'h7777_7777, 4'hF, rd, er, lat);
    check("err_wr40", {31'd0, er}, 32'd1);
    xfer(1'b0, 8'h40, 32'h0, 4'h0, rd, er, lat);
    check("err_rd40",      {31'd0, er}, 32'd1);
    check("err_rd40_data", rd, 32'd0);

    xfer(1'b1, 8'h05, 32'h6666_6666, 4'hF, rd, er, lat);
    check("err_wr05", {31'd0, er}, 32'd1);
    xfer(1'b0, 8'h04, 32'h0, 4'h0, rd, er, lat);
    check("rd04_after_err", rd, 32'hDEADBEEF);
    xfer(1'b0, 8'h00, 32'h0, 4'h0, rd, er, lat);
    check("id_after_err", rd, 32'hA9B0_1000);

    // psel drops during WAIT: no pready, no write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C;
    pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (pready) seen = 1'b1;
    end
    check("abort_no_pready", {31'd0, seen}, 32'd0);
    xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, er, lat);
    check("abort_rd0c", rd, 32'd0);

    // back-to-back writes, second setup driven during the first pready cycle
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04;
    pwdata = 32'hAAAA_5555; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    n = 0;
    while (!pready && n < 40) begin
      tick();
      n++;
    end
    check("b2b_first_ready", {31'd0, pready}, 32'd1);
    r1 = cyc;
    penable = 1'b0; paddr = 8'h08; pwdata = 32'h1234_5678;
    tick();
    penable = 1'b1;
    n = 0;
    while (!pready && n < 40) begin
      tick();
      n++;
    end
    check("b2b_second_ready", {31'd0, pready}, 32'd1);
    check("b2b_gap", cyc - r1, 32'd4);
    psel = 1'b0; penable = 1'b0;
    tick();
    check("b2b_pulse", {31'd0, pready}, 32'd0);
    xfer(1'b0, 8'h04, 32'h0, 4'h0, rd, er, lat);
    check("b2b_rd04", rd, 32'hAAAA_5555);
    xfer(1'b0, 8'h08, 32'h0, 4'h0, rd, er, lat);
    check("b2b_rd08", rd, 32'h1234_5678);

    // reset in the WAIT state of a third transfer
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10;
    pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_pready", {31'd0, pready}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    tick();
    check("rst_hold_pready", {31'd0, pready}, 32'd0);
    rst_n = 1'b1;
    tick();
    for (int w = 1; w < 16; w++) begin
      xfer(1'b0, 8'(w * 4), 32'h0, 4'h0, rd, er, lat);
      check($sformatf("post_rst_word%0d", w), rd, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
